// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: burst read port between the arbiter (master) and the AXI bridge (slave).
//   ren/raddr/rlen : read address valid, burst start address, beats minus one
//   arready        : address accepted
//   rready         : arbiter ready for a data beat
//   rvalid/rdata   : data beat valid and payload
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ren;
  logic              arready;
  logic [ADDR_W-1:0] raddr;
  logic [3:0]        rlen;
  logic              rready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  modport master(output ren, raddr, rlen, rready, input arready, rvalid, rdata);
  modport slave(input ren, raddr, rlen, rready, output arready, rvalid, rdata);
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin arbiter of NUM_CH read requesters onto one burst read port.
//   clk, rst          : clock, asynchronous active-low reset
//   ch_req_i          : per-channel request level (dropping it after grant cancels the pulse)
//   ch_addr_i         : per-channel byte address, channel k at [k*ADDR_W +: ADDR_W]
//   ch_uncached_i     : 1 = single word, 0 = full line fill
//   ch_rvalid_o       : one-cycle completion pulse to the granted channel
//   ch_rdata_o        : shared line buffer, word i at [i*DATA_W +: DATA_W]
//   ch_busy_o         : granted channel, from ADDR through RESP
//   axi               : burst read port toward the AXI bridge
module mem_read_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_req_i,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr_i,
  input  logic [NUM_CH-1:0]            ch_uncached_i,
  output logic [NUM_CH-1:0]            ch_rvalid_o,
  output logic [LINE_WORDS*DATA_W-1:0] ch_rdata_o,
  output logic [NUM_CH-1:0]            ch_busy_o,
  mem_read_arbiter_if.master           axi
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(LINE_WORDS) + 1;
  localparam int OFF = $clog2(LINE_WORDS * DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t                               state;
  logic [CW-1:0]                        rr_ptr, grant, nxt;
  logic [BW-1:0]                        beat;
  logic                                 cancel, found, sel_unc;
  logic [ADDR_W-1:0]                    sel_addr, raddr_q;
  logic [3:0]                           rlen_q;
  logic                                 ren_q, rready_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0]    line_q;
  assign axi.ren    = ren_q;
  assign axi.raddr  = raddr_q;
  assign axi.rlen   = rlen_q;
  assign axi.rready = rready_q;
  assign ch_rdata_o = line_q;
  // first requester at or after rr_ptr, scanning upward with wrap
  always_comb begin
    int idx;
    nxt      = rr_ptr;
    sel_addr = '0;
    sel_unc  = 1'b0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!found && ch_req_i[idx]) begin
        found    = 1'b1;
        nxt      = CW'(idx);
        sel_addr = ch_addr_i[idx*ADDR_W +: ADDR_W];
        sel_unc  = ch_uncached_i[idx];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      beat        <= '0;
      cancel      <= 1'b0;
      raddr_q     <= '0;
      rlen_q      <= '0;
      ren_q       <= 1'b0;
      rready_q    <= 1'b0;
      line_q      <= '0;
      ch_rvalid_o <= '0;
      ch_busy_o   <= '0;
    end else begin
      ch_rvalid_o <= '0;
      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (found) begin
            grant     <= nxt;
            ch_busy_o <= NUM_CH'(1) << nxt;
            raddr_q   <= sel_unc ? sel_addr : sel_addr & LINE_MASK;
            rlen_q    <= sel_unc ? 4'd0 : 4'(LINE_WORDS - 1);
            ren_q     <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (!ch_req_i[grant]) cancel <= 1'b1;
          if (axi.arready) begin
            ren_q    <= 1'b0;
            rready_q <= 1'b1;
            beat     <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (!ch_req_i[grant]) cancel <= 1'b1;
          if (axi.rvalid) begin
            line_q[beat[BW-2:0]] <= axi.rdata;
            beat                 <= beat + 1'b1;
            // the beat count alone ends the burst; a drop seen on this edge still cancels
            if (32'(beat) == 32'(rlen_q)) begin
              rready_q    <= 1'b0;
              ch_rvalid_o <= (cancel || !ch_req_i[grant]) ? '0 : NUM_CH'(1) << grant;
              state       <= RESP;
            end
          end
        end
        RESP: begin
          rr_ptr    <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
          ch_busy_o <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed-vector bench for mem_read_arbiter with a small AXI read responder.
module tb_mem_read_arbiter;
  logic         clk, rst;
  logic [3:0]   ch_req, ch_unc, ch_rvalid, ch_busy;
  logic [127:0] ch_addr;
  logic [255:0] ch_rdata;
  int           n_vec, n_bad;
  int           ar_wait, gap_after, gap_len, beat_s;
  logic [31:0]  dbase;
  mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) axi ();
  mem_read_arbiter dut (
    .clk(clk), .rst(rst), .ch_req_i(ch_req), .ch_addr_i(ch_addr), .ch_uncached_i(ch_unc),
    .ch_rvalid_o(ch_rvalid), .ch_rdata_o(ch_rdata), .ch_busy_o(ch_busy), .axi(axi)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_pulse(input int max, output int cyc, output logic [3:0] m);
    cyc = 0;
    m = '0;
    while (m == '0 && cyc < max) begin
      @(negedge clk);
      cyc++;
      m = ch_rvalid;
    end
  endtask
  // responder: arready after ar_wait cycles of ren, then one beat per cycle with an optional gap
  initial begin
    int aw, gap_cnt;
    aw = 0;
    gap_cnt = 0;
    beat_s = 0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rdata = '0;
    forever begin
      @(negedge clk);
      axi.arready = 1'b0;
      axi.rvalid = 1'b0;
      if (axi.ren) begin
        if (aw < ar_wait) aw++;
        else begin
          axi.arready = 1'b1;
          aw = 0;
          beat_s = 0;
          gap_cnt = 0;
        end
      end else if (axi.rready) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin
          axi.rvalid = 1'b1;
          axi.rdata = dbase + 32'(beat_s);
          if (beat_s == gap_after) gap_cnt = gap_len;
          beat_s++;
        end
      end
    end
  end
  initial begin
    int cyc, n_got;
    int order[5];
    int exp_order[5];
    logic [3:0] m, saw;
    logic reissued;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    ch_req = '0;
    ch_unc = '0;
    ch_addr = '0;
    ar_wait = 0;
    gap_after = 99;
    gap_len = 0;
    dbase = '0;
    exp_order = '{0, 1, 2, 3, 0};
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({axi.ren, axi.rready, axi.raddr, axi.rlen, ch_rvalid, ch_busy}), 64'd0);
    chk("reset_line", 64'(|ch_rdata), 64'd0);
    rst = 1'b1;
    // all four request together; ch0 comes back during ch3's burst
    @(negedge clk);
    for (int k = 0; k < 4; k++) ch_addr[k*32 +: 32] = 32'h100 * k;
    ch_unc = 4'hF;
    ch_req = 4'hF;
    n_got = 0;
    reissued = 1'b0;
    for (int k = 0; k < 5; k++) order[k] = -1;
    for (int c = 0; c < 80 && n_got < 5; c++) begin
      @(negedge clk);
      if (ch_rvalid != '0) begin
        for (int k = 0; k < 4; k++) if (ch_rvalid[k]) order[n_got] = k;
        n_got++;
        ch_req = ch_req & ~ch_rvalid;
      end
      if (ch_busy[3] && !reissued) begin
        ch_req[0] = 1'b1;
        reissued = 1'b1;
      end
    end
    for (int k = 0; k < 5; k++) chk($sformatf("rr_grant%0d", k), 64'(order[k]), 64'(exp_order[k]));
    // single uncached word on channel 2
    @(negedge clk);
    ch_unc = 4'b0100;
    dbase = 32'h1234_5678;
    ch_addr[64 +: 32] = 32'hBFC0_0004;
    ch_req[2] = 1'b1;
    @(negedge clk);
    chk("unc_ren", 64'(axi.ren), 64'd1);
    chk("unc_raddr", 64'(axi.raddr), 64'hBFC0_0004);
    chk("unc_rlen", 64'(axi.rlen), 64'd0);
    chk("unc_busy", 64'(ch_busy), 64'b0100);
    wait_pulse(20, cyc, m);
    chk("unc_pulse", 64'(m), 64'b0100);
    chk("unc_lat", 64'(cyc), 64'd2);
    chk("unc_word0", 64'(ch_rdata[31:0]), 64'h1234_5678);
    ch_req[2] = 1'b0;
    @(negedge clk);
    chk("unc_pulse_off", 64'(ch_rvalid), 64'd0);
    // cached line on channel 0 with a 2-cycle gap after beat 3
    @(negedge clk);
    ch_unc = '0;
    dbase = 32'hA000_0000;
    gap_after = 3;
    gap_len = 2;
    ch_addr[0 +: 32] = 32'h0000_101C;
    ch_req[0] = 1'b1;
    @(negedge clk);
    chk("line_raddr", 64'(axi.raddr), 64'h0000_1000);
    chk("line_rlen", 64'(axi.rlen), 64'd7);
    wait_pulse(40, cyc, m);
    chk("line_pulse", 64'(m), 64'b0001);
    chk("line_lat", 64'(cyc), 64'd11);
    for (int i = 0; i < 8; i++) chk($sformatf("line_word%0d", i), 64'(ch_rdata[i*32 +: 32]), 64'(32'hA000_0000 + i));
    ch_req[0] = 1'b0;
    gap_after = 99;
    // channel 1 cancels during the data phase
    @(negedge clk);
    dbase = 32'hC000_0000;
    ch_addr[32 +: 32] = 32'h0000_2000;
    ch_req[1] = 1'b1;
    saw = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      saw = saw | ch_rvalid;
      if (axi.rready && beat_s >= 3) ch_req[1] = 1'b0;
      if (!ch_req[1] && ch_busy == '0) break;
    end
    chk("cancel_done", 64'({ch_req[1], ch_busy}), 64'd0);
    chk("cancel_no_pulse", 64'(saw), 64'd0);
    chk("cancel_beats", 64'(beat_s), 64'd8);
    @(negedge clk);
    ch_unc = 4'b1000;
    dbase = 32'h0000_0055;
    ch_addr[96 +: 32] = 32'h3000_0008;
    ch_req[3] = 1'b1;
    wait_pulse(20, cyc, m);
    chk("after_cancel_pulse", 64'(m), 64'b1000);
    chk("after_cancel_lat", 64'(cyc), 64'd3);
    chk("after_cancel_word0", 64'(ch_rdata[31:0]), 64'h55);
    ch_req[3] = 1'b0;
    // address backpressure: arready low for 5 cycles
    @(negedge clk);
    ch_unc = '0;
    ar_wait = 5;
    dbase = 32'h7700_0000;
    ch_addr[64 +: 32] = 32'h2000_0044;
    ch_req[2] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), 64'({axi.ren, axi.rready, axi.raddr, axi.rlen}), 64'({1'b1, 1'b0, 32'h2000_0040, 4'd7}));
    end
    @(negedge clk);
    chk("bp_ren_last", 64'({axi.ren, axi.rready}), 64'b10);
    @(negedge clk);
    chk("bp_data", 64'({axi.ren, axi.rready}), 64'b01);
    ar_wait = 0;
    wait_pulse(40, cyc, m);
    chk("bp_pulse", 64'(m), 64'b0100);
    chk("bp_lat", 64'(cyc), 64'd8);
    chk("bp_word7", 64'(ch_rdata[224 +: 32]), 64'h7700_0007);
    ch_req[2] = 1'b0;
    // asynchronous reset in the middle of channel 3's line fill
    @(negedge clk);
    dbase = 32'h0;
    ch_addr[96 +: 32] = 32'h4000_0000;
    ch_req[3] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (axi.rready && beat_s >= 3) break;
    end
    chk("rst_mid_data", 64'(axi.rready), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outs", 64'({axi.ren, axi.rready, axi.raddr, axi.rlen, ch_rvalid, ch_busy}), 64'd0);
    chk("rst_async_line", 64'(|ch_rdata), 64'd0);
    ch_req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ch_unc = 4'b1010;
    ch_addr[32 +: 32] = 32'h0000_0010;
    ch_req = 4'b1010;
    @(negedge clk);
    chk("rst_rr_grant", 64'(ch_busy), 64'b0010);
    wait_pulse(20, cyc, m);
    chk("rst_first_pulse", 64'(m), 64'b0010);
    ch_req[1] = 1'b0;
    wait_pulse(20, cyc, m);
    chk("rst_second_pulse", 64'(m), 64'b1000);
    ch_req[3] = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Parametrised read-side successor to the cache/uncached muxing at the cache top. Arbitrates NUM_CH independent requesters (ICache, DCache, uncached inst, uncached data, ...) onto one burst read port toward the AXI bridge. Cached requests fetch a full line; uncached requests fetch one word. Round-robin fairness, registered outputs, and a per-channel cancel path for flush.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels, 1..8.
- ADDR_W, 32: address width.
- DATA_W, 32: beat width.
- LINE_WORDS, 8: words per cache line; power of two, 2..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ch_req_i  in  NUM_CH  per-channel read request level.
- ch_addr_i  in  NUM_CH*ADDR_W  per-channel byte address; channel k at [k*ADDR_W +: ADDR_W].
- ch_uncached_i  in  NUM_CH  1 = single-word access, 0 = line fill.
- ch_rvalid_o  out  NUM_CH  one-cycle completion pulse.
- ch_rdata_o  out  LINE_WORDS*DATA_W  shared line buffer; word i at [i*DATA_W +: DATA_W]. Valid only while some ch_rvalid_o bit is high.
- ch_busy_o  out  NUM_CH  channel currently granted, from ADDR through RESP.
- axi_ren_o  out  1  read address valid.
- axi_arready_i  in  1  address accepted.
- axi_raddr_o  out  ADDR_W  burst start address.
- axi_rlen_o  out  4  beats minus one.
- axi_rready_o  out  1  ready for data beat.
- axi_rvalid_i  in  1  data beat valid.
- axi_rdata_i  in  DATA_W  data beat.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: if any ch_req_i is set, grant the first requesting channel at or after rr_ptr, scanning upward with wrap. Latch that channel's address and uncached flag, then go to ADDR. If no requests, stay in IDLE.
- Address formation:
  - Cached: low log2(LINE_WORDS*DATA_W/8) address bits forced to 0; rlen = LINE_WORDS-1.
  - Uncached: address passes unmodified; rlen = 0.
- ADDR: axi_ren_o=1 with a stable addr/len. When axi_ren_o & axi_arready_i, go to DATA with beat counter = 0.
- DATA: axi_rready_o=1. On each axi_rvalid_i, write axi_rdata_i into buffer word [beat] and increment beat (width log2(LINE_WORDS)+1). The beat with index rlen moves to RESP. No rlast is used; the beat count is authoritative.
- RESP: for one cycle, ch_rvalid_o[grant] = 1 unless the grant is cancelled. rr_ptr ← grant+1 modulo NUM_CH. Go to IDLE.
  - Uncached data sits in buffer word 0. Other words hold stale data.
- Cancel: if ch_req_i[grant] drops at any time after the grant, set a sticky cancel flag. The burst still runs to completion, because AXI cannot abort. In RESP the pulse is suppressed and rr_ptr still advances. The flag clears in IDLE.
- Simultaneous requests: only one channel is granted. The others wait at level and are not lost.
- A requester must drop its request in the cycle after its pulse. The FSM passes through IDLE, so the same request is never re-granted in the RESP cycle.
- Channel inputs other than ch_req_i[grant] are ignored after the grant. ch_addr_i changes after the grant are ignored.

## Timing
- Reset values: state IDLE, rr_ptr 0, cancel 0, buffer 0. All outputs 0: axi_ren_o, axi_rready_o, axi_raddr_o, axi_rlen_o, ch_rvalid_o, ch_busy_o, ch_rdata_o.
- Reset asserted mid-burst returns immediately to IDLE with no pulse. Any outstanding AXI beats are the bridge's responsibility.
- All outputs are registered.
- Latency, with requests sampled in IDLE at cycle t:
  - axi_ren_o high at t+1.
  - With arready at t+1, DATA starts at t+2.
  - With back-to-back rvalid, the last beat is at t+2+rlen.
  - ch_rvalid_o is high at t+3+rlen: t+3 uncached, t+10 for an 8-word line.
- Minimum IDLE-to-IDLE gap between grants: 1 cycle.
- rvalid gaps stall the beat counter. axi_rready_o stays high throughout DATA.

## Test plan
- Single uncached, channel 2, addr 0xBFC0_0004, immediate arready and rvalid data 0x1234_5678:
  - raddr 0xBFC0_0004, rlen 0.
  - ch_rvalid_o = 4'b0100 exactly at t+3, word0 = 0x1234_5678.
- Cached, channel 0, addr 0x0000_101C, LINE_WORDS=8, rvalid beats 0..7 with a 2-cycle gap after beat 3:
  - raddr 0x0000_1000, rlen 7.
  - Words in order; pulse one cycle after beat 7.
- All four channels request together and hold:
  - Grants in order 0,1,2,3.
  - Channel 0 re-requests during channel 3's burst and is granted next; rr_ptr wraps.
- Cancel: channel 1 drops its request during DATA beat 2:
  - All 8 beats still accepted.
  - ch_rvalid_o stays 0; the next grant proceeds normally.
- Backpressure: arready held low for 5 cycles:
  - axi_ren_o, raddr and rlen stable for all 5 cycles.
  - DATA entered only after the handshake.
- Reset pulse (rst low) asynchronously mid-DATA:
  - All outputs 0 immediately.
  - After release, a new request is served from rr_ptr 0.
